bp_update_scheduler: RTL and testbench

Sequencer sitting between branch resolution in execute and the pattern history table (PHT) of the bimodal/GShare predictors. It clears the PHT after reset or on request, then queues resolved-branch updates and issues them to the predictor's update port. Updates are issued no faster than one every two cycles, which is the predictor's read-modify-write constraint. Upstream can therefore retire branches back-to-back without violating the predictor contract.

---
 rtl/bp_pkg.sv | 17 +
 rtl/bp_update_fifo.sv | 64 ++++++
 rtl/bp_update_scheduler.sv | 140 ++++++++++++++
 tb/tb_bp_update_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch-predictor update scheduler.
package bp_pkg;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } bp_sched_state_t;

    // Weakly not-taken: the value every PHT entry holds after a sweep.
    localparam logic [1:0] BP_INIT_VALUE = 2'b01;

    function automatic int bp_count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Synchronous FIFO of resolved-branch updates; flush empties it in one edge.
module bp_update_fifo
    import bp_pkg::*;
#(
    parameter type T     = logic [8:0],
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = bp_count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_flush,
    input  logic             i_push,
    input  T                 i_data,
    input  logic             i_pop,
    output T                 o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // A full FIFO refuses a push even when a pop happens on the same edge.
    assign w_push = i_push & ~o_full & ~i_flush;
    assign w_pop  = i_pop & ~o_empty & ~i_flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bp_update_scheduler.sv
// Sweeps the PHT to INIT_VALUE, then drains queued branch updates to the
// predictor at most once every two cycles (read-modify-write spacing).
module bp_update_scheduler
    import bp_pkg::*;
#(
    parameter int         INDEX_WIDTH = 8,
    parameter int         QUEUE_DEPTH = 4,
    parameter logic [1:0] INIT_VALUE  = BP_INIT_VALUE
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       req_valid,
    input  logic [INDEX_WIDTH-1:0]     req_index,
    input  logic                       req_taken,
    output logic                       req_ready,
    input  logic                       reinit,
    output logic                       upd_valid,
    output logic [INDEX_WIDTH-1:0]     upd_index,
    output logic                       upd_taken,
    output logic                       clr_we,
    output logic [INDEX_WIDTH-1:0]     clr_addr,
    output logic [1:0]                 clr_data,
    output logic                       init_busy,
    output bp_sched_state_t            dbg_state,
    output logic [$clog2(QUEUE_DEPTH):0] dbg_count
);

    localparam int CNT_W = bp_count_width(QUEUE_DEPTH);
    localparam logic [INDEX_WIDTH-1:0] LAST_ADDR = '1;

    typedef struct packed {
        logic [INDEX_WIDTH-1:0] index;
        logic                   taken;
    } bp_update_t;

    bp_sched_state_t        r_state;
    logic [INDEX_WIDTH-1:0] r_clr_addr;
    logic                   r_clr_we;
    logic                   r_init_busy;
    logic                   r_upd_valid;
    logic [INDEX_WIDTH-1:0] r_upd_index;
    logic                   r_upd_taken;

    bp_update_t             w_push_data;
    bp_update_t             w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_flush;
    logic [CNT_W-1:0]       w_count;

    // Valid/ready: an update transfers on any edge where req_valid & req_ready.
    // A push coinciding with an accepted reinit is dropped by the flush.
    assign req_ready   = ~w_full & ~r_init_busy;
    assign w_push      = req_valid & req_ready;
    assign w_push_data = '{index: req_index, taken: req_taken};
    assign w_flush     = reinit & (r_state != S_INIT);
    assign w_pop       = (r_state == S_RUN) & ~w_empty & ~reinit;

    bp_update_fifo #(
        .T     (bp_update_t),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_INIT;
            r_clr_addr  <= '0;
            r_clr_we    <= 1'b0;
            r_init_busy <= 1'b1;
            r_upd_valid <= 1'b0;
            r_upd_index <= '0;
            r_upd_taken <= 1'b0;
        end else begin
            r_upd_valid <= 1'b0;
            case (r_state)
                S_INIT: begin
                    // clr_we is low only on the first cycle out of reset.
                    if (!r_clr_we) begin
                        r_clr_we <= 1'b1;
                    end else if (r_clr_addr == LAST_ADDR) begin
                        r_clr_we    <= 1'b0;
                        r_init_busy <= 1'b0;
                        r_clr_addr  <= '0;
                        r_state     <= S_RUN;
                    end else begin
                        r_clr_addr <= r_clr_addr + 1'b1;
                    end
                end
                S_RUN: begin
                    if (reinit) begin
                        r_state     <= S_INIT;
                        r_clr_addr  <= '0;
                        r_clr_we    <= 1'b1;
                        r_init_busy <= 1'b1;
                    end else if (w_pop) begin
                        r_upd_valid <= 1'b1;
                        r_upd_index <= w_head.index;
                        r_upd_taken <= w_head.taken;
                        r_state     <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (reinit) begin
                        r_state     <= S_INIT;
                        r_clr_addr  <= '0;
                        r_clr_we    <= 1'b1;
                        r_init_busy <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign upd_valid = r_upd_valid;
    assign upd_index = r_upd_index;
    assign upd_taken = r_upd_taken;
    assign clr_we    = r_clr_we;
    assign clr_addr  = r_clr_addr;
    assign clr_data  = INIT_VALUE;
    assign init_busy = r_init_busy;
    assign dbg_state = r_state;
    assign dbg_count = w_count;

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Bench for bp_update_scheduler: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_bp_update_scheduler;
    import bp_pkg::*;

    localparam int IW = 6;
    localparam int QD = 4;
    localparam int N  = 1 << IW;
    localparam int CW = $clog2(QD) + 1;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            req_valid = 1'b0;
    logic [IW-1:0]   req_index = '0;
    logic            req_taken = 1'b0;
    logic            reinit = 1'b0;
    logic            req_ready;
    logic            upd_valid;
    logic [IW-1:0]   upd_index;
    logic            upd_taken;
    logic            clr_we;
    logic [IW-1:0]   clr_addr;
    logic [1:0]      clr_data;
    logic            init_busy;
    bp_sched_state_t dbg_state;
    logic [CW-1:0]   dbg_count;

    bp_update_scheduler #(
        .INDEX_WIDTH (IW),
        .QUEUE_DEPTH (QD)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_index (req_index),
        .req_taken (req_taken),
        .req_ready (req_ready),
        .reinit    (reinit),
        .upd_valid (upd_valid),
        .upd_index (upd_index),
        .upd_taken (upd_taken),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .clr_data  (clr_data),
        .init_busy (init_busy),
        .dbg_state (dbg_state),
        .dbg_count (dbg_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_issued = 0;
    logic prev_upd = 1'b0;

    // Reference model: pending updates in order, sweep progress, last issue.
    logic [IW:0]   exp_q[$];
    bit            m_busy = 1'b1;
    bit            m_clr_we = 1'b0;
    int            m_addr = 0;
    bit            m_upd = 1'b0;
    logic [IW-1:0] m_idx = '0;
    bit            m_tk = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model across one clock edge using the inputs now driven.
    task automatic model_edge();
        logic [IW:0] item;
        bit          room;
        if (!rstn) begin
            exp_q.delete();
            m_busy = 1'b1; m_clr_we = 1'b0; m_addr = 0;
            m_upd = 1'b0; m_idx = '0; m_tk = 1'b0;
        end else if (m_busy) begin
            m_upd = 1'b0;
            if (!m_clr_we) begin
                m_clr_we = 1'b1; m_addr = 0;
            end else if (m_addr == N - 1) begin
                m_clr_we = 1'b0; m_busy = 1'b0; m_addr = 0;
            end else begin
                m_addr++;
            end
        end else begin
            room = (exp_q.size() < QD);
            if (reinit) begin
                exp_q.delete();
                m_busy = 1'b1; m_clr_we = 1'b1; m_addr = 0; m_upd = 1'b0;
            end else begin
                // Issues are spaced: never on the cycle right after another.
                if (!m_upd && exp_q.size() > 0) begin
                    item = exp_q.pop_front();
                    m_upd = 1'b1; m_idx = item[IW:1]; m_tk = item[0];
                end else begin
                    m_upd = 1'b0;
                end
                if (req_valid && room) exp_q.push_back({req_index, req_taken});
            end
        end
    endtask

    task automatic tick();
        bit was_reset;
        was_reset = !rstn;
        model_edge();
        @(posedge clk);
        #1;
        chk("clr_we", clr_we, m_clr_we);
        chk("clr_addr", clr_addr, m_addr);
        chk("init_busy", init_busy, m_busy);
        chk("upd_valid", upd_valid, m_upd);
        if (m_upd || was_reset) begin
            chk("upd_index", upd_index, m_idx);
            chk("upd_taken", upd_taken, m_tk);
        end
        chk("req_ready", req_ready, !m_busy && exp_q.size() < QD);
        chk("count", dbg_count, exp_q.size());
        chk("clr_data", clr_data, 2'b01);
        chk("state", dbg_state, m_busy ? S_INIT : (m_upd ? S_GAP : S_RUN));
        chk("we_and_upd", clr_we & upd_valid, 1'b0);
        if (upd_valid === 1'b1) begin
            chk("upd_back_to_back", prev_upd, 1'b0);
            n_issued++;
        end
        prev_upd = upd_valid;
    endtask

    initial begin
        int  n_clr;
        int  acc;
        int  guard;
        int  base;
        bit  saw_block;

        // Reset values
        rstn = 1'b0;
        repeat (3) tick();
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_busy", init_busy, 1'b1);
        chk("rst_clr_we", clr_we, 1'b0);

        // Sweep after release
        rstn = 1'b1;
        n_clr = 0;
        for (int i = 0; i < N + 1; i++) begin
            tick();
            if (clr_we === 1'b1) n_clr++;
        end
        chk("sweep_len", n_clr, N);
        chk("ready_after_sweep", req_ready, 1'b1);

        // Single push, two-cycle latency, one-cycle pulse
        req_valid = 1'b1; req_index = 6'h2A; req_taken = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("lat_e0_valid", upd_valid, 1'b0);
        tick();
        chk("lat_e1_valid", upd_valid, 1'b1);
        chk("lat_e1_index", upd_index, 6'h2A);
        chk("lat_e1_taken", upd_taken, 1'b1);
        tick();
        chk("lat_e2_valid", upd_valid, 1'b0);

        // Back-to-back offers until the FIFO fills and refuses
        saw_block = 1'b0; acc = 0; base = n_issued;
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            req_index = IW'(i * 5 + 3);
            req_taken = 1'(i);
            if (req_ready !== 1'b1) saw_block = 1'b1;
            else acc++;
            tick();
        end
        req_valid = 1'b0;
        repeat (2 * QD + 4) tick();
        chk("full_refused", saw_block, 1'b1);
        chk("drained", dbg_count, 0);
        chk("all_issued", n_issued - base, acc);

        // Random traffic with occasional reinit
        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_index = IW'($urandom);
            req_taken = 1'($urandom);
            reinit    = ($urandom_range(0, 49) == 0);
            tick();
        end
        reinit = 1'b0; req_valid = 1'b0;
        repeat (N + 4) tick();

        // reinit with three entries queued
        req_valid = 1'b1; guard = 0;
        while (exp_q.size() < 3 && guard < 30) begin
            req_index = IW'($urandom);
            req_taken = 1'($urandom);
            tick();
            guard++;
        end
        chk("fill3_bound", exp_q.size() >= 3, 1'b1);
        reinit = 1'b1;
        tick();
        reinit = 1'b0; req_valid = 1'b0;
        chk("reinit_count", dbg_count, 0);
        chk("reinit_clr_we", clr_we, 1'b1);
        chk("reinit_addr", clr_addr, 0);
        base = n_issued;
        repeat (N + 12) tick();
        chk("reinit_no_issue", n_issued - base, 0);

        // Reset mid-run with an update pending
        req_valid = 1'b1; req_index = 6'h15; req_taken = 1'b0;
        tick();
        req_valid = 1'b0;
        rstn = 1'b0;
        tick();
        chk("midrst_valid", upd_valid, 1'b0);
        chk("midrst_count", dbg_count, 0);
        chk("midrst_busy", init_busy, 1'b1);
        chk("midrst_index", upd_index, 0);
        rstn = 1'b1;
        base = n_issued;
        repeat (N + 12) tick();
        chk("midrst_no_issue", n_issued - base, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
